regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 11 +
 rtl/regfile_sb_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/regfile_sb.sv | 78 +++++++
 tb/tb_regfile_sb.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared CPU package for the register file.
// Holds the default data width, register count and register-address type.
package regfile_sb_pkg;

  localparam int unsigned CPU_XLEN = 32;
  localparam int unsigned CPU_NREG = 32;
  localparam int unsigned CPU_AW   = $clog2(CPU_NREG);

  typedef logic [CPU_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Requester-side bus of the scoreboarded register file:
// operand reads, issue handshake, writeback and the busy vector.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN = CPU_XLEN,
  parameter int unsigned NREG = CPU_NREG
);

  localparam int unsigned AW = $clog2(NREG);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [NREG-1:0] busy;

  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_rd, wb_en, wb_addr, wb_data,
    input  rs1_data, rs2_data, issue_ready, busy
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, issue_rd, wb_en, wb_addr, wb_data,
    output rs1_data, rs2_data, issue_ready, busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks outstanding writes and decides whether an
// instruction may issue (RAW on both sources, WAW on the destination).
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned NREG = CPU_NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] i_rs1_addr,
  input  logic [$clog2(NREG)-1:0] i_rs2_addr,
  input  logic                    i_issue_valid,
  input  logic [$clog2(NREG)-1:0] i_issue_rd,
  input  logic                    i_wb_en,
  input  logic [$clog2(NREG)-1:0] i_wb_addr,
  output logic                    o_issue_ready,
  output logic [NREG-1:0]         o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_rs1_blk;
  logic            w_rs2_blk;
  logic            w_rd_blk;
  logic            w_ready;
  logic            w_wb_live;
  logic            w_issue_fire;

  // A same-cycle writeback to the register releases the block immediately.
  always_comb begin
    w_rs1_blk    = r_busy[i_rs1_addr] && !(i_wb_en && (i_wb_addr == i_rs1_addr));
    w_rs2_blk    = r_busy[i_rs2_addr] && !(i_wb_en && (i_wb_addr == i_rs2_addr));
    w_rd_blk     = r_busy[i_issue_rd] && !(i_wb_en && (i_wb_addr == i_issue_rd));
    w_ready      = !w_rs1_blk && !w_rs2_blk && !w_rd_blk;
    w_wb_live    = i_wb_en && (i_wb_addr != '0);
    w_issue_fire = i_issue_valid && w_ready && (i_issue_rd != '0);

    // Clear first, then set, so a same-register issue+writeback stays busy.
    w_busy_nxt = r_busy;
    if (w_wb_live) begin
      w_busy_nxt[i_wb_addr] = 1'b0;
    end
    if (w_issue_fire) begin
      w_busy_nxt[i_issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_issue_ready = w_ready;
  assign o_busy        = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file: two combinational read ports with writeback
// bypass, one write port, x0 hardwired to zero, issue gating via busy bits.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN = CPU_XLEN,
  parameter int unsigned NREG = CPU_NREG
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wb_live;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_issue_ready;
  logic [NREG-1:0] w_busy;
  logic [AW-1:0]   w_rs1_addr;
  logic [AW-1:0]   w_rs2_addr;
  logic [AW-1:0]   w_wb_addr;

  assign w_rs1_addr = bus.rs1_addr;
  assign w_rs2_addr = bus.rs2_addr;
  assign w_wb_addr  = bus.wb_addr;
  assign w_wb_live  = bus.wb_en && (w_wb_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_live) begin
      r_regs[w_wb_addr] <= bus.wb_data;
    end
  end

  // Entry 0 is never written, but reads of x0 are forced to zero regardless.
  always_comb begin
    w_rs1_data = r_regs[w_rs1_addr];
    if (w_rs1_addr == '0) begin
      w_rs1_data = '0;
    end else if (w_wb_live && (w_wb_addr == w_rs1_addr)) begin
      w_rs1_data = bus.wb_data;
    end

    w_rs2_data = r_regs[w_rs2_addr];
    if (w_rs2_addr == '0) begin
      w_rs2_data = '0;
    end else if (w_wb_live && (w_wb_addr == w_rs2_addr)) begin
      w_rs2_data = bus.wb_data;
    end
  end

  regfile_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_rs1_addr    (w_rs1_addr),
    .i_rs2_addr    (w_rs2_addr),
    .i_issue_valid (bus.issue_valid),
    .i_issue_rd    (bus.issue_rd),
    .i_wb_en       (bus.wb_en),
    .i_wb_addr     (w_wb_addr),
    .o_issue_ready (w_issue_ready),
    .o_busy        (w_busy)
  );

  assign bus.rs1_data    = w_rs1_data;
  assign bus.rs2_data    = w_rs2_data;
  assign bus.issue_ready = w_issue_ready;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: array/bitmask reference model checked every
// cycle at the falling edge, plus literal expectations for each scenario.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic check_en;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain register array and busy mask.
  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_busy;

  function automatic logic m_wb_hits(input reg_addr_t a);
    return bus.wb_en && (bus.wb_addr == a);
  endfunction

  function automatic logic m_ready();
    logic blk;
    blk = 1'b0;
    if (m_busy[bus.rs1_addr] && !m_wb_hits(bus.rs1_addr)) blk = 1'b1;
    if (m_busy[bus.rs2_addr] && !m_wb_hits(bus.rs2_addr)) blk = 1'b1;
    if (m_busy[bus.issue_rd] && !m_wb_hits(bus.issue_rd)) blk = 1'b1;
    return !blk;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input reg_addr_t a);
    if (a == 0) return '0;
    if (m_wb_hits(a)) return bus.wb_data;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    logic rdy;
    rdy = m_ready();
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (bus.wb_en && bus.wb_addr != 0) begin
        m_regs[bus.wb_addr] = bus.wb_data;
        m_busy[bus.wb_addr] = 1'b0;
      end
      if (bus.issue_valid && rdy && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_rs1", 64'(bus.rs1_data), 64'(m_read(bus.rs1_addr)));
      check("model_rs2", 64'(bus.rs2_data), 64'(m_read(bus.rs2_addr)));
      check("model_ready", 64'(bus.issue_ready), 64'(m_ready()));
      check("model_busy", 64'(bus.busy), 64'(m_busy));
    end
  end

  task automatic drive(input logic r, input reg_addr_t a1, input reg_addr_t a2,
                       input logic iv, input reg_addr_t rd,
                       input logic we, input reg_addr_t wa, input logic [XLEN-1:0] wd);
    rst             = r;
    bus.rs1_addr    = a1;
    bus.rs2_addr    = a2;
    bus.issue_valid = iv;
    bus.issue_rd    = rd;
    bus.wb_en       = we;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
  endtask

  // Outputs for the current inputs are examined at the falling edge.
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reg_addr_t a;
    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    m_busy   = '0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, '0);
    next_cycle();
    next_cycle();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, '0);
    check_en = 1'b1;

    // Post-reset: every address reads zero, nothing busy, ready high.
    for (int i = 0; i < NREG; i++) begin
      a = reg_addr_t'(i);
      drive(1'b0, a, reg_addr_t'(NREG - 1 - i), 1'b0, 0, 1'b0, 0, '0);
      to_neg();
      check("reset_rs1", 64'(bus.rs1_data), 64'h0);
      check("reset_rs2", 64'(bus.rs2_data), 64'h0);
      if (i == 0) begin
        check("reset_busy", 64'(bus.busy), 64'h0);
        check("reset_ready", 64'(bus.issue_ready), 64'h1);
      end
      next_cycle();
    end

    // Write-through bypass then stored value.
    drive(1'b0, 5, 0, 1'b0, 0, 1'b1, 5, 32'hDEADBEEF);
    to_neg();
    check("bypass_x5", 64'(bus.rs1_data), 64'hDEADBEEF);
    next_cycle();
    drive(1'b0, 5, 5, 1'b0, 0, 1'b0, 0, '0);
    to_neg();
    check("stored_x5", 64'(bus.rs1_data), 64'hDEADBEEF);
    next_cycle();

    // x0 discards writes and never becomes busy.
    drive(1'b0, 0, 5, 1'b1, 0, 1'b1, 0, 32'h12345678);
    to_neg();
    check("x0_bypass", 64'(bus.rs1_data), 64'h0);
    check("x0_ready", 64'(bus.issue_ready), 64'h1);
    next_cycle();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, '0);
    to_neg();
    check("x0_read", 64'(bus.rs1_data), 64'h0);
    check("x0_busy", 64'(bus.busy), 64'h0);
    next_cycle();

    // RAW on x7, released by a same-cycle writeback.
    drive(1'b0, 0, 0, 1'b1, 7, 1'b0, 0, '0);
    to_neg();
    check("issue7_ready", 64'(bus.issue_ready), 64'h1);
    next_cycle();
    drive(1'b0, 7, 0, 1'b1, 8, 1'b0, 0, '0);
    to_neg();
    check("raw7_blocked", 64'(bus.issue_ready), 64'h0);
    check("busy7_set", 64'(bus.busy), 64'h80);
    next_cycle();
    drive(1'b0, 7, 0, 1'b1, 8, 1'b1, 7, 32'h55);
    to_neg();
    check("raw7_released", 64'(bus.issue_ready), 64'h1);
    check("raw7_data", 64'(bus.rs1_data), 64'h55);
    next_cycle();
    drive(1'b0, 0, 7, 1'b0, 0, 1'b0, 0, '0);
    to_neg();
    check("busy7_clr_8_set", 64'(bus.busy), 64'h100);
    check("x7_stored", 64'(bus.rs2_data), 64'h55);
    next_cycle();

    // Writeback clears x8; then same-cycle issue and writeback on x9.
    drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 8, 32'h88);
    next_cycle();
    drive(1'b0, 0, 0, 1'b1, 9, 1'b1, 9, 32'hA5);
    to_neg();
    check("x9_ready", 64'(bus.issue_ready), 64'h1);
    next_cycle();
    drive(1'b0, 9, 8, 1'b0, 0, 1'b0, 0, '0);
    to_neg();
    check("set_wins_busy", 64'(bus.busy), 64'h200);
    check("set_wins_data", 64'(bus.rs1_data), 64'hA5);
    check("x8_stored", 64'(bus.rs2_data), 64'h88);
    next_cycle();

    // WAW on the destination and RAW on rs2.
    drive(1'b0, 0, 0, 1'b1, 9, 1'b0, 0, '0);
    to_neg();
    check("waw9_blocked", 64'(bus.issue_ready), 64'h0);
    next_cycle();
    drive(1'b0, 0, 9, 1'b1, 4, 1'b0, 0, '0);
    to_neg();
    check("raw_rs2_blocked", 64'(bus.issue_ready), 64'h0);
    next_cycle();

    // Reset drops outstanding writes and clears storage.
    drive(1'b0, 0, 0, 1'b1, 3, 1'b0, 0, '0);
    next_cycle();
    drive(1'b1, 3, 9, 1'b1, 4, 1'b1, 3, 32'h77);
    to_neg();
    check("rst_pre_busy", 64'(bus.busy), 64'h208);
    next_cycle();
    drive(1'b0, 3, 9, 1'b0, 0, 1'b0, 0, '0);
    to_neg();
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_x3", 64'(bus.rs1_data), 64'h0);
    check("rst_x9", 64'(bus.rs2_data), 64'h0);
    check("rst_ready", 64'(bus.issue_ready), 64'h1);
    next_cycle();
    drive(1'b0, 3, 0, 1'b0, 0, 1'b1, 3, 32'h1);
    to_neg();
    check("late_wb_bypass", 64'(bus.rs1_data), 64'h1);
    next_cycle();
    drive(1'b0, 3, 3, 1'b0, 0, 1'b0, 0, '0);
    to_neg();
    check("late_wb_stored", 64'(bus.rs1_data), 64'h1);
    check("late_wb_busy", 64'(bus.busy), 64'h0);
    next_cycle();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
